// File: rtl/fas_pkg.sv
// Shared constants and types for the FIR-to-FFT sequencer and peak analyser.
package fas_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned IdxW      = $clog2(FRAME_LEN);

  typedef enum logic {
    StIdle,
    StStream
  } stream_state_e;

  // Unsigned re^2 + im^2 for the default sample width.
  typedef logic [2*DW:0] mag_t;

endpackage

// File: rtl/fas_frame_buf.sv
// Two-bank ping-pong sample store: fills banks alternately, reports full flags and
// holds a sticky overflow flag for samples dropped while both banks are full.
module fas_frame_buf import fas_pkg::*; #(
  parameter int unsigned DW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_valid_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            rd_bank_i,
  input  logic [IdxW-1:0] rd_idx_i,
  input  logic            free_i,
  output logic [1:0]      full_o,
  output logic [DW-1:0]   rd_data_o,
  output logic            overflow_o
);

  logic [DW-1:0]   mem_q [2][FRAME_LEN];
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
  logic            overflow_q, overflow_d;
  logic            tgt_bank;
  logic            wr_en;

  always_comb begin
    // A bank still being streamed may sit at wr_bank after a drop; fill the free one.
    tgt_bank   = full_q[wr_bank_q] ? ~wr_bank_q : wr_bank_q;
    wr_en      = wr_valid_i && !(&full_q);
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (free_i) begin
      full_d[rd_bank_i] = 1'b0;
    end
    if (wr_valid_i && (&full_q)) begin
      overflow_d = 1'b1;
    end
    if (wr_en) begin
      wr_bank_d = tgt_bank;
      wr_ptr_d  = wr_ptr_q + IdxW'(1);
      if (wr_ptr_q == IdxW'(FRAME_LEN - 1)) begin
        full_d[tgt_bank] = 1'b1;
        wr_bank_d        = ~tgt_bank;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      mem_q[tgt_bank][wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o     = full_q;
  assign rd_data_o  = mem_q[rd_bank_i][rd_idx_i];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/fas_seq.sv
// FIR sample sequencer into an FFT engine plus peak-bin tracker over NUM_FRAMES frames.
// Define FAS_SEQ_DC_SKIP_EN to exclude bin 0 from the peak search.
module fas_seq import fas_pkg::*; #(
  parameter int unsigned NUM_FRAMES = 64,
  parameter int unsigned DW         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fir_valid,
  input  logic [DW-1:0]        fir_d,
  output logic                 fft_in_valid,
  input  logic                 fft_in_ready,
  output logic [DW-1:0]        fft_in_data,
  output logic                 fft_in_last,
  input  logic                 bin_valid,
  input  logic signed [DW-1:0] bin_re,
  input  logic signed [DW-1:0] bin_im,
  output logic                 fft_valid,
  output logic                 done,
  output logic [3:0]           freq,
  output logic                 overflow
);

  localparam int unsigned SqW  = 2 * DW;
  localparam int unsigned MagW = 2 * DW + 1;
  localparam int unsigned FcW  = $clog2(NUM_FRAMES + 1);

  // Streamer
  stream_state_e   state_q, state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            free;
  logic [1:0]      full;
  logic [DW-1:0]   buf_data;

  fas_frame_buf #(
    .DW (DW)
  ) u_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (fir_valid),
    .wr_data_i  (fir_d),
    .rd_bank_i  (rd_bank_q),
    .rd_idx_i   (rd_idx_q),
    .free_i     (free),
    .full_o     (full),
    .rd_data_o  (buf_data),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    free         = 1'b0;
    fft_in_valid = (state_q == StStream);
    fft_in_last  = fft_in_valid && (rd_idx_q == IdxW'(FRAME_LEN - 1));
    fft_in_data  = fft_in_valid ? buf_data : '0;
    unique case (state_q)
      StIdle: begin
        if (full[rd_bank_q]) begin
          state_d  = StStream;
          rd_idx_d = '0;
        end
      end
      StStream: begin
        if (fft_in_ready) begin
          rd_idx_d = rd_idx_q + IdxW'(1);
          if (fft_in_last) begin
            free      = 1'b1;
            rd_bank_d = ~rd_bank_q;
            // Banks fill alternately, so the other bank is the next oldest.
            if (!full[~rd_bank_q]) begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // Peak tracker
  logic signed [SqW-1:0] re_sq, im_sq;
  logic [MagW-1:0]       mag;
  logic [MagW-1:0]       peak_mag_q, peak_mag_d;
  logic [3:0]            peak_idx_q, peak_idx_d;
  logic [IdxW-1:0]       bin_idx_q, bin_idx_d;
  logic [FcW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                  fft_valid_q, fft_valid_d;
  logic                  done_q, done_d;
  logic                  bin_ok;
  logic                  consider;

  assign re_sq = SqW'(bin_re) * SqW'(bin_re);
  assign im_sq = SqW'(bin_im) * SqW'(bin_im);
  assign mag   = {1'b0, re_sq} + {1'b0, im_sq};

  always_comb begin
    bin_ok      = bin_valid && !done_q && (frame_cnt_q != FcW'(NUM_FRAMES));
`ifdef FAS_SEQ_DC_SKIP_EN
    consider    = (bin_idx_q != '0);
`else
    consider    = 1'b1;
`endif
    peak_mag_d  = peak_mag_q;
    peak_idx_d  = peak_idx_q;
    bin_idx_d   = bin_idx_q;
    frame_cnt_d = frame_cnt_q;
    fft_valid_d = 1'b0;
    done_d      = done_q | (frame_cnt_q == FcW'(NUM_FRAMES));
    if (bin_ok) begin
      bin_idx_d = bin_idx_q + IdxW'(1);
      // Strictly greater keeps the earliest bin on ties.
      if (consider && (mag > peak_mag_q)) begin
        peak_mag_d = mag;
        peak_idx_d = 4'(bin_idx_q);
      end
      if (bin_idx_q == IdxW'(FRAME_LEN - 1)) begin
        fft_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + FcW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      bin_idx_q   <= '0;
      frame_cnt_q <= '0;
      fft_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      peak_mag_q  <= peak_mag_d;
      peak_idx_q  <= peak_idx_d;
      bin_idx_q   <= bin_idx_d;
      frame_cnt_q <= frame_cnt_d;
      fft_valid_q <= fft_valid_d;
      done_q      <= done_d;
    end
  end

  assign fft_valid = fft_valid_q;
  assign done      = done_q;
  assign freq      = done_q ? peak_idx_q : 4'd0;

endmodule

// File: tb/tb_fas_seq.sv
// Scoreboard bench for fas_seq: random FIR/ready traffic against a frame-level model,
// plus bin sequences checked against a plain peak-search model.
module tb_fas_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned NF = 2;
`ifdef FAS_SEQ_DC_SKIP_EN
  localparam bit DcSkip = 1'b1;
`else
  localparam bit DcSkip = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 fir_valid = 1'b0;
  logic [DW-1:0]        fir_d = '0;
  logic                 fft_in_valid;
  logic                 fft_in_ready = 1'b0;
  logic [DW-1:0]        fft_in_data;
  logic                 fft_in_last;
  logic                 bin_valid = 1'b0;
  logic signed [DW-1:0] bin_re = '0;
  logic signed [DW-1:0] bin_im = '0;
  logic                 fft_valid;
  logic                 done;
  logic [3:0]           freq;
  logic                 overflow;

  fas_seq #(
    .NUM_FRAMES (NF),
    .DW         (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fir_valid    (fir_valid),
    .fir_d        (fir_d),
    .fft_in_valid (fft_in_valid),
    .fft_in_ready (fft_in_ready),
    .fft_in_data  (fft_in_data),
    .fft_in_last  (fft_in_last),
    .bin_valid    (bin_valid),
    .bin_re       (bin_re),
    .bin_im       (bin_im),
    .fft_valid    (fft_valid),
    .done         (done),
    .freq         (freq),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 0: ready high, 1: ready low, 2: toggle, 3: random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       fft_in_ready = 1'b1;
      1:       fft_in_ready = 1'b0;
      2:       fft_in_ready = ~fft_in_ready;
      default: fft_in_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Frame-level model: samples queue up, frames complete every 16 accepted samples,
  // at most two complete frames held, freed when their 16th sample is taken.
  logic [DW-1:0] exp_q[$];
  int            full_cnt = 0;
  int            partial = 0;
  int            str_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  int            fv_cnt = 0;
  logic          done_prev = 1'b0;
  int            exp_freq_q[$];

  always @(negedge clk) begin
    logic          hs_last;
    logic [DW-1:0] e;
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (!done) chk("freq_zero_before_done", 64'(freq), 64'd0);
    if (done && !done_prev) begin
      if (exp_freq_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got done=1 required no done");
      end else begin
        chk("freq_at_done", 64'(freq), 64'(exp_freq_q.pop_front()));
      end
    end
    done_prev = done;
    if (rst) begin
      exp_q.delete();
      full_cnt  = 0;
      partial   = 0;
      str_cnt   = 0;
      m_ovf     = 1'b0;
      hold_pend = 1'b0;
      fv_cnt    = 0;
    end else begin
      if (fft_valid) fv_cnt++;
      if (fft_in_valid && hold_pend) chk("data_stable", 64'(fft_in_data), 64'(hold_data));
      hold_pend = fft_in_valid && !fft_in_ready;
      hold_data = fft_in_data;
      hs_last = 1'b0;
      if (fft_in_valid && fft_in_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected: got data=%0d required no sample", fft_in_data);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 64'(fft_in_data), 64'(e));
          chk("stream_last", 64'(fft_in_last), 64'(str_cnt == 15));
          hs_last = (str_cnt == 15);
          str_cnt = (str_cnt + 1) % 16;
        end
      end
      if (fir_valid) begin
        if (full_cnt == 2) begin
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back(fir_d);
          partial++;
          if (partial == 16) begin
            full_cnt++;
            partial = 0;
          end
        end
      end
      if (hs_last) full_cnt--;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_in_valid"}, 64'(fft_in_valid), 64'd0);
    chk({tag, "_in_last"}, 64'(fft_in_last), 64'd0);
    chk({tag, "_in_data"}, 64'(fft_in_data), 64'd0);
    chk({tag, "_fft_valid"}, 64'(fft_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_freq"}, 64'(freq), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    fir_valid = 1'b0;
    bin_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero(tag);
    rst = 1'b0;
  endtask

  // kind 0: base+i sequential back to back, 1: random data with random gaps
  task automatic send_samples(input int n, input int kind, input int base);
    int i = 0;
    while (i < n) begin
      @(posedge clk);
      #1;
      if (kind == 1 && $urandom_range(0, 3) == 0) begin
        fir_valid = 1'b0;
      end else begin
        fir_valid = 1'b1;
        fir_d     = (kind == 0) ? DW'(base + i) : DW'($urandom());
        i++;
      end
    end
    @(posedge clk);
    #1;
    fir_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (c < 2000 && exp_q.size() != partial) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, 64'(exp_q.size()), 64'(partial));
  endtask

  // kind 0: tie case, 1: DC vs bin 15, 2: random
  task automatic run_bins(input int kind, input string tag);
    logic signed [DW-1:0] re_a[NF+1][16];
    logic signed [DW-1:0] im_a[NF+1][16];
    longint best, m;
    int     bidx, c, f, b;
    for (int fi = 0; fi <= NF; fi++) begin
      for (int bi = 0; bi < 16; bi++) begin
        case (kind)
          0: begin
            re_a[fi][bi] = (bi == 1) ? 16'sd100 : (bi == 15) ? 16'sd0 : 16'sd10;
            im_a[fi][bi] = (bi == 15) ? -16'sd100 : 16'sd0;
          end
          1: begin
            re_a[fi][bi] = (bi == 0) ? 16'sd500 : (bi == 15) ? 16'sd300 : 16'sd0;
            im_a[fi][bi] = (bi == 0) ? 16'sd500 : 16'sd0;
          end
          default: begin
            re_a[fi][bi] = DW'($urandom());
            im_a[fi][bi] = DW'($urandom());
          end
        endcase
        // Frames beyond NF must be ignored; make them tempting.
        if (fi == NF && bi == 3) begin
          re_a[fi][bi] = -16'sd32768;
          im_a[fi][bi] = -16'sd32768;
        end
      end
    end
    best = 0;
    bidx = 0;
    for (int fi = 0; fi < NF; fi++) begin
      for (int bi = 0; bi < 16; bi++) begin
        m = longint'(re_a[fi][bi]) * longint'(re_a[fi][bi]) +
            longint'(im_a[fi][bi]) * longint'(im_a[fi][bi]);
        if (!(DcSkip && bi == 0) && m > best) begin
          best = m;
          bidx = bi;
        end
      end
    end
    do_reset({tag, "_rst"});
    exp_freq_q.push_back(bidx);
    f = 0;
    b = 0;
    while (f <= NF) begin
      @(posedge clk);
      #1;
      if (kind == 2 && $urandom_range(0, 3) == 0) begin
        bin_valid = 1'b0;
      end else begin
        bin_valid = 1'b1;
        bin_re    = re_a[f][b];
        bin_im    = im_a[f][b];
        b++;
        if (b == 16) begin
          b = 0;
          f++;
        end
      end
    end
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    c = 0;
    while (c < 50 && !done) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_freq_held"}, 64'(freq), 64'(bidx));
    chk({tag, "_frames"}, 64'(fv_cnt), 64'(NF));
  endtask

  initial begin
    int c;
    rdy_mode = 0;
    @(posedge clk);
    do_reset("reset");

    // Two frames back to back with ready high.
    send_samples(32, 0, 1);
    wait_drain("seq_drain");
    chk("seq_overflow", 64'(overflow), 64'd0);

    // Ready low: third frame dropped, first frame held at its first sample.
    do_reset("stall_rst");
    rdy_mode = 1;
    send_samples(48, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_overflow", 64'(overflow), 64'd1);
    chk("stall_valid", 64'(fft_in_valid), 64'd1);
    chk("stall_data", 64'(fft_in_data), 64'd1);
    chk("stall_queued", 64'(exp_q.size()), 64'd32);
    rdy_mode = 0;
    wait_drain("stall_drain");

    // Ready toggling every cycle.
    do_reset("toggle_rst");
    rdy_mode = 2;
    send_samples(32, 0, 200);
    wait_drain("toggle_drain");

    // Random data, gaps and backpressure.
    do_reset("rand_rst");
    rdy_mode = 3;
    send_samples(160, 1, 0);
    rdy_mode = 0;
    wait_drain("rand_drain");

    // Reset while presenting index 7, then a fresh frame from index 0.
    do_reset("mid_rst");
    rdy_mode = 0;
    send_samples(16, 0, 1);
    c = 0;
    while (c < 200 && str_cnt != 7) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("mid_reached_idx7", 64'(str_cnt), 64'd7);
    do_reset("mid_abort");
    send_samples(16, 0, 101);
    wait_drain("mid_after_drain");
    chk("mid_after_overflow", 64'(overflow), 64'd0);

    run_bins(0, "bins_tie");
    run_bins(1, "bins_dc");
    run_bins(2, "bins_rand_a");
    run_bins(2, "bins_rand_b");
    chk("freq_queue_empty", 64'(exp_freq_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fas_seq.md
FAS_SEQ -- requirements
Module: fas_seq

Interface
REQ-001 Parameter SHALL be NUM_FRAMES, default 64, number of FFT frames before analysis completes.
REQ-002 Parameter SHALL be DW, default 16, sample/bin component width.
REQ-003 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: fir_valid  in  1  FIR sample strobe.
REQ-006 Port: fir_d  in  DW  FIR sample, 8.8 fixed point.
REQ-007 Port: fft_in_valid  out  1  sample offered to FFT engine.
REQ-008 Port: fft_in_ready  in  1  FFT engine accepts sample.
REQ-009 Port: fft_in_data  out  DW  offered sample.
REQ-010 Port: fft_in_last  out  1  marks 16th sample of frame.
REQ-011 Port: bin_valid  in  1  FFT bin strobe; bins arrive in order 0..15 per frame.
REQ-012 Port: bin_re, bin_im  in  DW each  signed bin components.
REQ-013 Port: fft_valid  out  1  one-cycle pulse per completed frame of bins.
REQ-014 Port: done  out  1  analysis complete.
REQ-015 Port: freq  out  4  peak bin index.
REQ-016 Port: overflow  out  1  sticky sample-drop flag.

Function
REQ-017 Block SHALL collect fir_d into two 16-entry ping-pong banks, write pointer 0..15 wrapping.
REQ-018 On 16th write a bank SHALL be marked full; writing SHALL switch to the other bank.
REQ-019 fir_valid while both banks full SHALL drop the sample and set overflow; write pointer SHALL NOT advance.
REQ-020 Streamer FSM states SHALL be IDLE and STREAM; IDLE->STREAM the cycle after a bank is full, serving the oldest full bank.
REQ-021 In STREAM, fft_in_valid SHALL be high, fft_in_data SHALL be held stable until fft_in_valid && fft_in_ready, read index advancing only on that handshake.
REQ-022 fft_in_last SHALL be high with index 15; on its handshake the bank SHALL be freed and FSM SHALL go IDLE, or stay STREAM if the other bank is full.
REQ-023 A fill and a free of the same bank in one cycle SHALL NOT occur; fill of one bank concurrent with streaming of the other SHALL proceed without stall.
REQ-024 Per bin, magnitude SHALL be re*re + im*im as 2*DW+1-bit unsigned, no truncation.
REQ-025 Peak tracker SHALL replace stored peak only on strictly greater magnitude (ties keep lower/earlier bin), over all frames.
REQ-026 fft_valid SHALL pulse the cycle after bin 15 of each frame; frame counter SHALL increment then.
REQ-027 After NUM_FRAMES frames, done SHALL rise the following cycle, freq SHALL show peak index, both held until rst; further bins SHALL be ignored.
REQ-028 freq SHALL read 0 until done.

Reset
REQ-029 rst SHALL clear banks' full flags, pointers, FSM to IDLE, peak, counters; outputs fft_in_valid, fft_in_last, fft_valid, done, overflow, freq, fft_in_data SHALL be 0 next cycle.
REQ-030 rst mid-stream SHALL abort the frame; no partial frame SHALL be resent.

Configuration
REQ-031 With FAS_SEQ_DC_SKIP_EN defined, bin 0 SHALL be excluded from peak search (freq never 0 from data); without it all 16 bins SHALL compete.

Structure
REQ-032 Package fas_pkg SHALL hold DW, FRAME_LEN=16, streamer state enum, magnitude type.
REQ-033 Ping-pong storage SHALL be sub-module fas_frame_buf; FSM, peak tracker, counters in fas_seq.

Verification
REQ-034 32 fir_valid samples 1..32, fft_in_ready=1 -> two frames streamed 1..16, 17..32, fft_in_last on 16 and 32, overflow=0.
REQ-035 fft_in_ready=0 throughout, 48 samples -> samples 33..48 dropped, overflow=1, first frame data stable at 1.
REQ-036 fft_in_ready toggling every cycle -> each sample presented until accepted, order unchanged.
REQ-037 NUM_FRAMES=2, bins with bin1=(100,0), bin15=(0,-100), others 10 -> fft_valid twice, done=1, freq=1 (tie, earlier bin).
REQ-038 Bin0=(500,500), bin15=(300,0) -> freq=15 with FAS_SEQ_DC_SKIP_EN, freq=0 without.
REQ-039 rst asserted at stream index 7 -> all outputs 0 next cycle; subsequent 16 samples stream from index 0.
